// File: rtl/serial_comparator_ctrl.sv
// serial_comparator_ctrl
//   Bit-serial WIDTH-bit magnitude comparator controller. Latches two operands
//   on an accepted start and walks them MSB-first through an external 1-bit
//   comparator cell, one bit per clock, resolving GT/EQ/LT for the full words.
//
//   Optional feature macro: EARLY_EXIT_EN
//     defined   : scan stops on the first unequal bit (latency 1..WIDTH).
//     undefined : every compare scans all WIDTH bits (fixed latency WIDTH);
//                 the first unequal bit is remembered in an internal
//                 "decided" flag and later bits cannot change the result.
//   In both builds a non-one-hot comparator response before a decision
//   aborts the scan with err=1.

module serial_comparator_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             bit_a,
  output logic             bit_b,
  input  logic             bit_gt,
  input  logic             bit_eq,
  input  logic             bit_lt,
  output logic             busy,
  output logic             done,
  output logic             GT,
  output logic             EQ,
  output logic             LT,
  output logic             err
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic             r_err;

  logic             w_onehot;
  logic             w_last;

  // A healthy comparator cell asserts exactly one of its three outputs.
  assign w_onehot = (bit_gt & ~bit_eq & ~bit_lt) |
                    (~bit_gt & bit_eq & ~bit_lt) |
                    (~bit_gt & ~bit_eq & bit_lt);
  assign w_last   = (r_idx == '0);

`ifndef EARLY_EXIT_EN
  // Full-scan build: the first unequal bit fixes the answer; the remaining
  // bits are walked only to keep latency constant.
  logic r_decided;
  logic r_dec_gt;
  logic w_decided;
  logic w_dec_gt;

  assign w_decided = r_decided | bit_gt | bit_lt;
  assign w_dec_gt  = r_decided ? r_dec_gt : bit_gt;
`endif

  // Drive the current operand bits to the shared comparator cell while scanning.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    bit_a = 1'b0;
    bit_b = 1'b0;
    if (r_state == S_SCAN) begin
      bit_a = r_a[r_idx];
      bit_b = r_b[r_idx];
    end
  end

  // Control FSM: accept, scan MSB-first, pulse done, return to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_gt      <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
      r_err     <= 1'b0;
`ifndef EARLY_EXIT_EN
      r_decided <= 1'b0;
      r_dec_gt  <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a       <= A;
            r_b       <= B;
            r_idx     <= IDX_W'(WIDTH - 1);
            r_gt      <= 1'b0;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
`ifndef EARLY_EXIT_EN
            r_decided <= 1'b0;
            r_dec_gt  <= 1'b0;
`endif
            r_state   <= S_SCAN;
          end
        end

        S_SCAN: begin
`ifdef EARLY_EXIT_EN
          if (!w_onehot) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (bit_gt) begin
            r_gt    <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (bit_lt) begin
            r_lt    <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_last) begin
            r_eq    <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx - IDX_W'(1);
          end
`else
          if (!r_decided && !w_onehot) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (!r_decided) begin
              r_decided <= w_decided;
              r_dec_gt  <= bit_gt;
            end
            if (w_last) begin
              if (w_decided) begin
                r_gt <= w_dec_gt;
                r_lt <= ~w_dec_gt;
              end else begin
                r_eq <= 1'b1;
              end
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx - IDX_W'(1);
            end
          end
`endif
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign GT   = r_gt;
  assign EQ   = r_eq;
  assign LT   = r_lt;
  assign err  = r_err;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Self-checking bench for serial_comparator_ctrl (WIDTH=8). A behavioural
// 1-bit comparator with fault injection is attached; expected results are
// queued when a compare is launched and checked when done is observed.

module tb_serial_comparator_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         bit_a;
  logic         bit_b;
  logic         bit_gt;
  logic         bit_eq;
  logic         bit_lt;
  logic         busy;
  logic         done;
  logic         GT;
  logic         EQ;
  logic         LT;
  logic         err;
  logic         fault;

  serial_comparator_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .bit_a  (bit_a),
    .bit_b  (bit_b),
    .bit_gt (bit_gt),
    .bit_eq (bit_eq),
    .bit_lt (bit_lt),
    .busy   (busy),
    .done   (done),
    .GT     (GT),
    .EQ     (EQ),
    .LT     (LT),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Behavioural comparator cell; 'fault' forces an all-zero response.
  always_comb begin
    bit_gt = bit_a & ~bit_b;
    bit_eq = (bit_a == bit_b);
    bit_lt = ~bit_a & bit_b;
    if (fault) begin
      bit_gt = 1'b0;
      bit_eq = 1'b0;
      bit_lt = 1'b0;
    end
  end

  typedef struct {
    logic       gt;
    logic       eq;
    logic       lt;
    logic       err;
    int         k;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           fault_at;  // scanned-bit number (1-based) to corrupt, 0 = none
    logic         gt;
    logic         eq;
    logic         lt;
    logic         err;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected number of scan cycles for a compare in the current build.
  function automatic int model_k(input logic [W-1:0] a, input logic [W-1:0] b, input int fault_at);
    bit decided;
    decided = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      int n;
      n = W - i;
      if (n == fault_at && !decided) return n;
      if (a[i] != b[i]) begin
`ifdef EARLY_EXIT_EN
        return n;
`else
        decided = 1'b1;
`endif
      end
    end
    return W;
  endfunction

  // Called #1 after the accepting edge; walks edges until done or budget out.
  task automatic wait_done(input logic [W-1:0] a, input logic [W-1:0] b, input int fault_at,
                           output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int c = 0; c < 3 * W; c++) begin
      fault = (cyc + 1 == fault_at);
      if (cyc < W) begin
        check("bit_a", bit_a, a[W-1-cyc]);
        check("bit_b", bit_b, b[W-1-cyc]);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    fault = 1'b0;
    if (!ok) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic pop_check(input int cyc);
    exp_t e;
    check("sb_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("GT", GT, e.gt);
      check("EQ", EQ, e.eq);
      check("LT", LT, e.lt);
      check("err", err, e.err);
      check("latency", cyc, e.k);
      check("busy_in_done", busy, 1);
      check("bits_zero_in_done", {bit_a, bit_b}, 2'b00);
    end
  endtask

  task automatic run_cmp(input vec_t v);
    int cyc;
    bit ok;
    @(negedge clk);
    A = v.a;
    B = v.b;
    start = 1'b1;
    exp_q.push_back('{gt: v.gt, eq: v.eq, lt: v.lt, err: v.err, k: model_k(v.a, v.b, v.fault_at)});
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~v.a;  // operands must only matter on the accepting edge
    B = ~v.b;
    check("busy_after_accept", busy, 1);
    check("done_after_accept", done, 0);
    check("cleared_after_accept", {GT, EQ, LT, err}, 4'b0000);
    wait_done(v.a, v.b, v.fault_at, cyc, ok);
    if (ok) begin
      pop_check(cyc);
      @(posedge clk);
      #1;
      check("done_pulse_width", done, 0);
      check("busy_fall", busy, 0);
      repeat (2) @(posedge clk);
      #1;
      check("held_result", {GT, EQ, LT, err}, {v.gt, v.eq, v.lt, v.err});
    end
  endtask

  vec_t vecs[10];

  initial begin
    int cyc;
    bit ok;

    vecs[0] = '{a: 8'hA5, b: 8'hA5, fault_at: 0, gt: 0, eq: 1, lt: 0, err: 0};
    vecs[1] = '{a: 8'h80, b: 8'h7F, fault_at: 0, gt: 1, eq: 0, lt: 0, err: 0};
    vecs[2] = '{a: 8'h10, b: 8'h11, fault_at: 0, gt: 0, eq: 0, lt: 1, err: 0};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, fault_at: 2, gt: 0, eq: 0, lt: 0, err: 1};
    vecs[4] = '{a: 8'hC0, b: 8'hA0, fault_at: 0, gt: 1, eq: 0, lt: 0, err: 0};
    vecs[5] = '{a: 8'h00, b: 8'hFF, fault_at: 0, gt: 0, eq: 0, lt: 1, err: 0};
    vecs[6] = '{a: 8'h81, b: 8'h80, fault_at: 0, gt: 1, eq: 0, lt: 0, err: 0};
    vecs[7] = '{a: 8'h80, b: 8'h7F, fault_at: 3, gt: 1, eq: 0, lt: 0, err: 0};
    vecs[8] = '{a: 8'h00, b: 8'h00, fault_at: 1, gt: 0, eq: 0, lt: 0, err: 1};
    vecs[9] = '{a: 8'h3C, b: 8'h3D, fault_at: 0, gt: 0, eq: 0, lt: 1, err: 0};

    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    fault = 1'b0;

    // Reset values.
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_results", {GT, EQ, LT, err}, 4'b0000);
    check("reset_bits", {bit_a, bit_b}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven compares.
    foreach (vecs[i]) run_cmp(vecs[i]);

    // Reset during SCAN: discard in-flight compare, no done pulse.
    @(negedge clk);
    A = 8'h5A;
    B = 8'h5A;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_results", {GT, EQ, LT, err}, 4'b0000);
    check("abort_bits", {bit_a, bit_b}, 2'b00);
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < W + 2; c++) begin
      @(posedge clk);
      #1;
      check("post_reset_idle", {busy, done}, 2'b00);
    end
    run_cmp('{a: 8'h5A, b: 8'h5A, fault_at: 0, gt: 0, eq: 1, lt: 0, err: 0});

    // start held through SCAN and DONE: only the first request runs,
    // results hold in IDLE, next acceptance at the first IDLE edge.
    @(negedge clk);
    A = 8'h80;
    B = 8'h7F;
    start = 1'b1;
    exp_q.push_back('{gt: 1, eq: 0, lt: 0, err: 0, k: model_k(8'h80, 8'h7F, 0)});
    @(posedge clk);
    #1;
    A = 8'h00;
    B = 8'hFF;
    wait_done(8'h80, 8'h7F, 0, cyc, ok);
    if (ok) begin
      pop_check(cyc);
      check("start_in_done", start, 1);
      @(posedge clk);
      #1;
      check("idle_after_done", {busy, done}, 2'b00);
      check("held_with_start_high", {GT, EQ, LT, err}, 4'b1000);
      exp_q.push_back('{gt: 0, eq: 0, lt: 1, err: 0, k: model_k(8'h00, 8'hFF, 0)});
      @(posedge clk);
      #1;
      start = 1'b0;
      check("reaccept_busy", busy, 1);
      check("reaccept_cleared", {GT, EQ, LT, err}, 4'b0000);
      wait_done(8'h00, 8'hFF, 0, cyc, ok);
      if (ok) pop_check(cyc);
      @(posedge clk);
      #1;
      check("final_idle", busy, 0);
    end
    start = 1'b0;

    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
